wishbone_bus_master: RTL and testbench
======================================

# wishbone_bus_master

- Sequences the single shared memory port of the multicycle core onto a Wishbone classic (B3, non-pipelined) bus.
- Accepts the controller's per-state `memory_command` (NONE/READ/WRITE) plus the data path's addresses, store data and byte selects.
- Runs one bus cycle per command, with error and timeout handling.
- Returns captured read data and a one-cycle `memory_done` that lets the controller leave its memory-wait state.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, bus-cycle cycles without ack/err before abort; counter is 8 bits, legal range 1–255

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- memory_command  in  2  controller_pkg::memory_command_t: NONE, READ, WRITE
- misaligned_exception  in  1  from data path; request must not reach the bus
- read_memory_address  in  32  address for READ
- write_memory_address  in  32  address for WRITE
- write_memory_data  in  32  store data, already lane-aligned
- store_sel  in  4  byte enables for WRITE
- read_data  out  32  last captured dat_i
- memory_done  out  1  one-cycle completion pulse
- bus_error  out  1  one-cycle, coincident with memory_done, on err_i or timeout
- cyc_o, stb_o, we_o  out  1 each  Wishbone master controls
- adr_o  out  32  address
- dat_o  out  32  write data
- sel_o  out  4  byte selects
- dat_i  in  32  slave read data
- ack_i, err_i  in  1 each  slave termination

## Operation
- States: bus_state_t = IDLE, BUS, DONE. Reset state is IDLE.
- Output reset values:
  - cyc_o, stb_o, we_o, memory_done, bus_error = 0
  - adr_o, dat_o, read_data = 0
  - sel_o = 0
- IDLE:
  - memory_command NONE: stay in IDLE.
  - READ or WRITE with misaligned_exception=1: go to DONE. No bus activity, bus_error=0 (the trap is raised by the controller).
  - READ: register adr_o=read_memory_address, we_o=0, sel_o=4'b1111, dat_o unchanged. Go to BUS with cyc_o=stb_o=1.
  - WRITE: register adr_o=write_memory_address, we_o=1, sel_o=store_sel, dat_o=write_memory_data. Go to BUS.
  - Clear the timeout counter.
- BUS:
  - cyc_o, stb_o, adr_o, we_o, dat_o and sel_o are held stable.
  - err_i=1: go to DONE with bus_error. err_i has priority over a simultaneous ack_i.
  - ack_i=1: go to DONE. If we_o=0, capture read_data<=dat_i.
  - Otherwise increment the counter. When the counter equals TIMEOUT_CYCLES-1 and neither ack_i nor err_i is present, abort to DONE with bus_error.
  - Leaving BUS drops cyc_o, stb_o and we_o on the same edge.
- DONE:
  - memory_done=1, and bus_error as latched.
  - Always go to IDLE; memory_command is ignored in this state.
- read_data:
  - Holds its value until the next successful READ.
  - Unchanged on write, error, timeout or misaligned requests.
- Controller contract:
  - Hold memory_command and its operands stable from issue through the DONE cycle.
  - A command present in the cycle after DONE is a new request.
- memory_command values outside the encoding are treated as NONE.

## Timing
- All outputs are registered; none are combinational from inputs.
- Zero-wait slave:
  - Request seen in cycle 0.
  - cyc_o/stb_o high in cycle 1; ack_i arrives in cycle 1.
  - memory_done and valid read_data in cycle 2.
  - Next request accepted in cycle 3.
- Latency is 2 + wait states from request to done.
- Timeout:
  - cyc_o is high for exactly TIMEOUT_CYCLES cycles.
  - memory_done/bus_error follow in the next cycle.
- Misaligned request: memory_done arrives one cycle after the request; cyc_o never rises.
- Reset asserted mid-cycle:
  - cyc_o and stb_o drop asynchronously; state returns to IDLE.
  - No memory_done is produced.
  - A slave ack_i arriving after reset is ignored.
- ack_i or err_i while cyc_o=0 is ignored.

## Structure
- In controller_pkg:
  - memory_command_t (NONE/READ/WRITE), already used by the controller and data path.
  - bus_state_t.
  - BUS_TIMEOUT_WIDTH=8.
- Single module; no sub-module is needed.
- The state register, timeout counter and output registers live in one always_ff with asynchronous reset.

## Test plan
- READ 0x0000_1000 against a zero-wait slave returning 0xDEAD_BEEF:
  - cyc_o/stb_o high exactly 1 cycle with we_o=0 and sel_o=1111.
  - The following cycle has memory_done=1, bus_error=0 and read_data=0xDEAD_BEEF.
- WRITE 0x0000_2002 with data 0x1234_0000 and store_sel=1100, slave inserting 3 wait states:
  - Bus signals stable for 4 cycles; dat_o=0x1234_0000, sel_o=1100, we_o=1.
  - memory_done arrives in the 5th cycle after issue.
  - read_data is unchanged.
- READ with misaligned_exception=1:
  - cyc_o stays 0.
  - memory_done=1 one cycle later, bus_error=0.
- Simultaneous ack_i=1 and err_i=1:
  - bus_error=1 and read_data not updated.
- TIMEOUT_CYCLES=4 with a silent slave:
  - cyc_o high 4 cycles, then memory_done=bus_error=1.
  - The next READ completes normally.
- Reset asserted on the second wait cycle of a READ:
  - cyc_o drops immediately, with no memory_done.
  - After release, a READ works and a late ack_i is ignored.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared controller types: memory command encoding, bus master states, timeout counter width.
// Used by the controller, data path and the Wishbone bus master.
package controller_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10
   } memory_command_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      DONE = 2'b10
   } bus_state_t;

   localparam int BUS_TIMEOUT_WIDTH = 8;

endpackage

// File: rtl/wishbone_bus_master_if.sv
// Wishbone classic (B3) signal bundle between the core's bus master and a single slave.
// The master modport drives the cycle controls; the slave modport drives data and termination.
interface wishbone_bus_master_if;
   logic        cyc_o;
   logic        stb_o;
   logic        we_o;
   logic [31:0] adr_o;
   logic [31:0] dat_o;
   logic [3:0]  sel_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        err_i;

   modport master (
      output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      input  dat_i, ack_i, err_i
   );

   modport slave (
      input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
      output dat_i, ack_i, err_i
   );
endinterface

// File: rtl/wishbone_bus_master.sv
// Runs one Wishbone classic cycle per memory_command; latency 2 + slave wait states to memory_done.
// The slave stalls by withholding ack_i/err_i; the cycle aborts with bus_error after TIMEOUT_CYCLES.
module wishbone_bus_master
   import controller_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  memory_command_t       memory_command,
   input  logic                  misaligned_exception,
   input  logic [31:0]           read_memory_address,
   input  logic [31:0]           write_memory_address,
   input  logic [31:0]           write_memory_data,
   input  logic [3:0]            store_sel,
   output logic [31:0]           read_data,
   output logic                  memory_done,
   output logic                  bus_error,
   wishbone_bus_master_if.master wb
);

   localparam logic [BUS_TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = BUS_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   bus_state_t                   state, state_nxt;
   logic [BUS_TIMEOUT_WIDTH-1:0] count, count_nxt;
   logic                         start_read, start_write;
   logic                         finish, fail, capture;

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      start_read  = 1'b0;
      start_write = 1'b0;
      finish      = 1'b0;
      fail        = 1'b0;
      capture     = 1'b0;
      unique case (state)
         IDLE: begin
            count_nxt = '0;
            // Encodings other than READ/WRITE fall through as NONE.
            if (memory_command == READ || memory_command == WRITE) begin
               if (misaligned_exception) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt   = BUS;
                  start_read  = (memory_command == READ);
                  start_write = (memory_command == WRITE);
               end
            end
         end
         BUS: begin
            if (wb.err_i) begin
               state_nxt = DONE;
               finish    = 1'b1;
               fail      = 1'b1;
            end else if (wb.ack_i) begin
               state_nxt = DONE;
               finish    = 1'b1;
               capture   = ~wb.we_o;
            end else if (count == TIMEOUT_LAST) begin
               state_nxt = DONE;
               finish    = 1'b1;
               fail      = 1'b1;
            end else begin
               count_nxt = count + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         wb.cyc_o    <= 1'b0;
         wb.stb_o    <= 1'b0;
         wb.we_o     <= 1'b0;
         wb.adr_o    <= '0;
         wb.dat_o    <= '0;
         wb.sel_o    <= '0;
         read_data   <= '0;
         memory_done <= 1'b0;
         bus_error   <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         memory_done <= (state_nxt == DONE);
         bus_error   <= fail;
         if (start_read) begin
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
            wb.we_o  <= 1'b0;
            wb.adr_o <= read_memory_address;
            wb.sel_o <= 4'b1111;
         end
         if (start_write) begin
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
            wb.we_o  <= 1'b1;
            wb.adr_o <= write_memory_address;
            wb.sel_o <= store_sel;
            wb.dat_o <= write_memory_data;
         end
         if (finish) begin
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
         end
         if (capture) begin
            read_data <= wb.dat_i;
         end
      end
   end

endmodule

// File: tb/tb_wishbone_bus_master.sv
// Directed bench for wishbone_bus_master: transaction-level expected trace checked every cycle,
// plus literal latency / cycle-length / data expectations per scenario.
module tb_wishbone_bus_master;
   import controller_pkg::*;

   localparam int TO = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   memory_command_t memory_command = NONE;
   logic            misaligned_exception = 1'b0;
   logic [31:0]     read_memory_address = '0;
   logic [31:0]     write_memory_address = '0;
   logic [31:0]     write_memory_data = '0;
   logic [3:0]      store_sel = '0;
   logic [31:0]     read_data;
   logic            memory_done;
   logic            bus_error;

   wishbone_bus_master_if wb();

   wishbone_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                  (clk),
      .reset                (reset),
      .memory_command       (memory_command),
      .misaligned_exception (misaligned_exception),
      .read_memory_address  (read_memory_address),
      .write_memory_address (write_memory_address),
      .write_memory_data    (write_memory_data),
      .store_sel            (store_sel),
      .read_data            (read_data),
      .memory_done          (memory_done),
      .bus_error            (bus_error),
      .wb                   (wb)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc_no = 0;
   int cyc_hi = 0;
   int done_cyc = -1;
   int issue_cyc = 0;

   // Expected DUT outputs for the current cycle
   logic        exp_cyc = 0, exp_stb = 0, exp_we = 0, exp_done = 0, exp_err = 0;
   logic [31:0] exp_adr = '0, exp_dat = '0, exp_rdata = '0;
   logic [3:0]  exp_sel = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) cyc_no++;

   always @(negedge clk) begin
      if (memory_done === 1'b1) done_cyc = cyc_no;
      if (wb.cyc_o === 1'b1) cyc_hi++;
      chk("cyc_o",       32'(wb.cyc_o),    32'(exp_cyc));
      chk("stb_o",       32'(wb.stb_o),    32'(exp_stb));
      chk("we_o",        32'(wb.we_o),     32'(exp_we));
      chk("adr_o",       wb.adr_o,         exp_adr);
      chk("dat_o",       wb.dat_o,         exp_dat);
      chk("sel_o",       32'(wb.sel_o),    32'(exp_sel));
      chk("read_data",   read_data,        exp_rdata);
      chk("memory_done", 32'(memory_done), 32'(exp_done));
      chk("bus_error",   32'(bus_error),   32'(exp_err));
   end

   // term: 0 = ack, 1 = err, 2 = ack+err together, 3 = silent slave
   task automatic transact(input memory_command_t cmd, input logic [31:0] addr,
                           input logic [31:0] wdat, input logic [3:0] sel, input logic mis,
                           input int waits, input int term, input logic [31:0] rdat);
      logic wr;
      int   n;
      wr = (cmd == WRITE);
      memory_command       = cmd;
      misaligned_exception = mis;
      read_memory_address  = wr ? ~addr : addr;
      write_memory_address = wr ? addr : ~addr;
      write_memory_data    = wdat;
      store_sel            = sel;
      wb.dat_i             = ~rdat;
      issue_cyc            = cyc_no;
      done_cyc             = -1;
      cyc_hi               = 0;
      step();
      if (!mis) begin
         exp_cyc = 1'b1;
         exp_stb = 1'b1;
         exp_we  = wr;
         exp_adr = addr;
         exp_sel = wr ? sel : 4'hF;
         if (wr) exp_dat = wdat;
         n = (term == 3) ? TO : waits + 1;
         for (int i = 0; i < n; i++) begin
            if (i == n - 1 && term != 3) begin
               wb.ack_i = (term != 1);
               wb.err_i = (term != 0);
               wb.dat_i = rdat;
            end
            step();
         end
         wb.ack_i = 1'b0;
         wb.err_i = 1'b0;
         wb.dat_i = ~rdat;
         exp_cyc  = 1'b0;
         exp_stb  = 1'b0;
         exp_we   = 1'b0;
         exp_err  = (term != 0);
         if (term == 0 && !wr) exp_rdata = rdat;
      end else begin
         exp_err = 1'b0;
      end
      exp_done = 1'b1;
      step();
      exp_done             = 1'b0;
      exp_err              = 1'b0;
      memory_command       = NONE;
      misaligned_exception = 1'b0;
   endtask

   initial begin
      wb.ack_i = 1'b0;
      wb.err_i = 1'b0;
      wb.dat_i = '0;
      step();
      step();
      chk("reset_cyc",   32'(wb.cyc_o), 32'd0);
      chk("reset_rdata", read_data,     32'h0);
      reset = 1'b0;
      step();

      // Zero-wait READ
      transact(READ, 32'h0000_1000, 32'hFFFF_FFFF, 4'h0, 1'b0, 0, 0, 32'hDEAD_BEEF);
      chk("rd0_latency", 32'(done_cyc - issue_cyc), 32'd2);
      chk("rd0_cyc_len", 32'(cyc_hi), 32'd1);
      chk("rd0_data",    read_data, 32'hDEAD_BEEF);

      // WRITE with 3 wait states, issued back-to-back
      transact(WRITE, 32'h0000_2002, 32'h1234_0000, 4'b1100, 1'b0, 3, 0, 32'h5A5A_5A5A);
      chk("wr_latency", 32'(done_cyc - issue_cyc), 32'd5);
      chk("wr_cyc_len", 32'(cyc_hi), 32'd4);
      chk("wr_rdata",   read_data, 32'hDEAD_BEEF);

      // Misaligned READ never reaches the bus
      transact(READ, 32'h0000_3001, 32'h0, 4'h0, 1'b1, 0, 0, 32'h1111_1111);
      chk("mis_latency", 32'(done_cyc - issue_cyc), 32'd1);
      chk("mis_cyc_len", 32'(cyc_hi), 32'd0);

      // ack_i and err_i together: error wins, no capture
      transact(READ, 32'h0000_4000, 32'h0, 4'h0, 1'b0, 1, 2, 32'h5555_5555);
      chk("both_rdata", read_data, 32'hDEAD_BEEF);

      // err_i alone, zero-wait
      transact(READ, 32'h0000_4004, 32'h0, 4'h0, 1'b0, 0, 1, 32'h6666_6666);

      // Silent slave: timeout after TO cycles
      transact(READ, 32'h0000_5000, 32'h0, 4'h0, 1'b0, 0, 3, 32'h7777_7777);
      chk("to_cyc_len", 32'(cyc_hi), 32'd4);
      chk("to_latency", 32'(done_cyc - issue_cyc), 32'd5);

      // Next READ completes normally
      transact(READ, 32'h0000_5004, 32'h0, 4'h0, 1'b0, 2, 0, 32'hCAFE_F00D);
      chk("post_to_data",    read_data, 32'hCAFE_F00D);
      chk("post_to_latency", 32'(done_cyc - issue_cyc), 32'd4);

      // Out-of-range command encoding behaves as NONE
      memory_command = memory_command_t'(2'b11);
      done_cyc = -1;
      cyc_hi   = 0;
      repeat (3) step();
      memory_command = NONE;
      step();
      chk("bad_cmd_cyc",  32'(cyc_hi), 32'd0);
      chk("bad_cmd_done", 32'(done_cyc), 32'hFFFF_FFFF);

      // Reset on the second wait cycle of a READ
      memory_command      = READ;
      read_memory_address = 32'h0000_6000;
      done_cyc            = -1;
      step();
      exp_cyc = 1'b1;
      exp_stb = 1'b1;
      exp_we  = 1'b0;
      exp_adr = 32'h0000_6000;
      exp_sel = 4'hF;
      step();
      #2;
      exp_cyc   = 1'b0;
      exp_stb   = 1'b0;
      exp_adr   = '0;
      exp_dat   = '0;
      exp_sel   = '0;
      exp_rdata = '0;
      reset     = 1'b1;
      #1;
      chk("rst_async_cyc", 32'(wb.cyc_o), 32'd0);
      chk("rst_async_stb", 32'(wb.stb_o), 32'd0);
      step();
      memory_command = NONE;
      step();
      reset = 1'b0;
      wb.ack_i = 1'b1;
      wb.dat_i = 32'h7777_0000;
      step();
      wb.ack_i = 1'b0;
      step();
      chk("rst_no_done", 32'(done_cyc), 32'hFFFF_FFFF);

      transact(READ, 32'h0000_7000, 32'h0, 4'h0, 1'b0, 1, 0, 32'h0BAD_F00D);
      chk("post_rst_data",    read_data, 32'h0BAD_F00D);
      chk("post_rst_latency", 32'(done_cyc - issue_cyc), 32'd3);

      step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
